arith_req_scheduler: RTL and testbench

//  Round-robin scheduler sharing one arithmetic_core between two requesters.

---
 rtl/arith_req_scheduler.sv | 168 ++++++++++++++++
 tb/tb_arith_req_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arith_req_scheduler.sv
// Round-robin scheduler sharing one arithmetic_core between two requesters (one op in flight).
// Define ARITH_SCHED_STICKY_EN to enable the sticky carry/overflow flags.

module arithmetic_core #(
   parameter int WIDTH = 4
) (
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero
);
   logic [WIDTH-1:0] rhs;
   logic             sub;
   logic [WIDTH:0]   sum;

   always_comb begin
      rhs      = op[1] ? WIDTH'(1) : b;
      sub      = op[0];
      sum      = sub ? ({1'b0, a} - {1'b0, rhs}) : ({1'b0, a} + {1'b0, rhs});
      result   = sum[WIDTH-1:0];
      // the extra bit is carry-out for ADD/INC and borrow (a < rhs) for SUB/DEC
      carry    = sum[WIDTH];
      overflow = (a[WIDTH-1] == (rhs[WIDTH-1] ^ sub)) && (result[WIDTH-1] != a[WIDTH-1]);
      zero     = (result == '0);
   end
endmodule

module arith_req_scheduler #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [1:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [1:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry,
   output logic             rsp_overflow,
   output logic             rsp_zero,
   output logic             busy,
   input  logic             sticky_clr,
   output logic             sticky_carry,
   output logic             sticky_ovf
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   logic [1:0]       state;
   logic             last_grant;
   logic             grant;
   logic             accept;
   logic [1:0]       op_p0;
   logic [WIDTH-1:0] a_p0;
   logic [WIDTH-1:0] b_p0;
   logic             id_p0;
   logic [WIDTH-1:0] core_result;
   logic             core_carry;
   logic             core_overflow;
   logic             core_zero;

   // a lone requester always wins; otherwise the one not served last
   always_comb begin
      grant = ~last_grant;
      if (req0_valid && !req1_valid)
         grant = 1'b0;
      else if (req1_valid && !req0_valid)
         grant = 1'b1;
   end

   assign req0_ready = (state == IDLE) && !grant;
   assign req1_ready = (state == IDLE) && grant;
   assign accept     = grant ? (req1_valid && req1_ready) : (req0_valid && req0_ready);
   assign busy       = (state != IDLE);

   // stage 0: operand capture on handshake
   always_ff @(posedge clk) begin
      if (accept) begin
         op_p0 <= grant ? req1_op : req0_op;
         a_p0  <= grant ? req1_a  : req0_a;
         b_p0  <= grant ? req1_b  : req0_b;
         id_p0 <= grant;
      end
   end

   arithmetic_core #(.WIDTH(WIDTH)) u_core (
      .op       (op_p0),
      .a        (a_p0),
      .b        (b_p0),
      .result   (core_result),
      .carry    (core_carry),
      .overflow (core_overflow),
      .zero     (core_zero)
   );

   // stage 1: result capture and response handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         last_grant   <= 1'b1;
         rsp_valid    <= 1'b0;
         rsp_id       <= 1'b0;
         rsp_result   <= '0;
         rsp_carry    <= 1'b0;
         rsp_overflow <= 1'b0;
         rsp_zero     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= EXEC;
                  last_grant <= grant;
               end
            end
            EXEC: begin
               state        <= RESP;
               rsp_valid    <= 1'b1;
               rsp_id       <= id_p0;
               rsp_result   <= core_result;
               rsp_carry    <= core_carry;
               rsp_overflow <= core_overflow;
               rsp_zero     <= core_zero;
            end
            RESP: begin
               if (rsp_ready) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ARITH_SCHED_STICKY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_carry <= 1'b0;
         sticky_ovf   <= 1'b0;
      end else if (sticky_clr) begin
         sticky_carry <= 1'b0;
         sticky_ovf   <= 1'b0;
      end else if (state == EXEC) begin
         if (core_carry)
            sticky_carry <= 1'b1;
         if (core_overflow)
            sticky_ovf <= 1'b1;
      end
   end
`else
   // sticky_clr is folded in only so the port stays referenced
   assign sticky_carry = sticky_clr & 1'b0;
   assign sticky_ovf   = sticky_clr & 1'b0;
`endif
endmodule

// File: tb/tb_arith_req_scheduler.sv
// Self-checking bench for arith_req_scheduler: directed steps followed by a randomized run
// checked against a transaction-level reference model.

module tb_arith_req_scheduler;
   localparam int WIDTH = 4;
   localparam logic [1:0] ADD = 2'd0;
   localparam logic [1:0] SUB = 2'd1;
   localparam logic [1:0] INC = 2'd2;
   localparam logic [1:0] DEC = 2'd3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req0_valid = 1'b0, req1_valid = 1'b0;
   logic       req0_ready, req1_ready;
   logic [1:0] req0_op = 2'd0, req1_op = 2'd0;
   logic [3:0] req0_a = 4'd0, req0_b = 4'd0, req1_a = 4'd0, req1_b = 4'd0;
   logic       rsp_valid, rsp_ready = 1'b0, rsp_id;
   logic [3:0] rsp_result;
   logic       rsp_carry, rsp_overflow, rsp_zero, busy;
   logic       sticky_clr = 1'b0, sticky_carry, sticky_ovf;

   int n_checks = 0;
   int n_fail   = 0;

   arith_req_scheduler #(.WIDTH(WIDTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req0_valid   (req0_valid),
      .req0_ready   (req0_ready),
      .req0_op      (req0_op),
      .req0_a       (req0_a),
      .req0_b       (req0_b),
      .req1_valid   (req1_valid),
      .req1_ready   (req1_ready),
      .req1_op      (req1_op),
      .req1_a       (req1_a),
      .req1_b       (req1_b),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_id       (rsp_id),
      .rsp_result   (rsp_result),
      .rsp_carry    (rsp_carry),
      .rsp_overflow (rsp_overflow),
      .rsp_zero     (rsp_zero),
      .busy         (busy),
      .sticky_clr   (sticky_clr),
      .sticky_carry (sticky_carry),
      .sticky_ovf   (sticky_ovf)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int id, input logic v, input logic [1:0] op,
                          input logic [3:0] a, input logic [3:0] b);
      if (id == 0) begin
         req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
      end else begin
         req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
      end
   endtask

   // Arithmetic reference in plain integers: unsigned range for carry, signed range for overflow.
   function automatic void ref_op(input logic [1:0] op, input int a, input int b,
                                  output int res, output bit c, output bit o, output bit z);
      int sa, sb, full, sfull;
      sa = (a > 7) ? a - 16 : a;
      sb = (b > 7) ? b - 16 : b;
      case (op)
         ADD:     begin full = a + b; sfull = sa + sb; end
         SUB:     begin full = a - b; sfull = sa - sb; end
         INC:     begin full = a + 1; sfull = sa + 1;  end
         default: begin full = a - 1; sfull = sa - 1;  end
      endcase
      res = ((full % 16) + 16) % 16;
      c   = (full > 15) || (full < 0);
      o   = (sfull > 7) || (sfull < -8);
      z   = (res == 0);
   endfunction

   task automatic do_op(input int id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] er, input logic ec, input logic eo, input logic ez);
      rsp_ready = 1'b1;
      set_req(id, 1'b1, op, a, b);
      #1;
      check("op_ready", id ? req1_ready : req0_ready, 1);
      tick();
      set_req(id, 1'b0, op, a, b);
      #1;
      check("exec_busy", busy, 1);
      check("exec_rsp_valid", rsp_valid, 0);
      tick();
      check("rsp_valid", rsp_valid, 1);
      check("rsp_id", rsp_id, id[0]);
      check("rsp_result", rsp_result, er);
      check("rsp_carry", rsp_carry, ec);
      check("rsp_overflow", rsp_overflow, eo);
      check("rsp_zero", rsp_zero, ez);
      tick();
      check("done_rsp_valid", rsp_valid, 0);
      check("done_busy", busy, 0);
      check("rsp_hold", rsp_result, er);
   endtask

   initial begin
      int seen, last_t;
      bit pend[2];
      logic [1:0] pop[2];
      logic [3:0] pa[2], pb[2];
      bit inflight, m_last, g, exec_edge;
      int age;
      int n_res, e_res;
      bit n_c, n_o, n_z, n_id, e_c, e_o, e_z, e_id, m_sc, m_so;

      // reset values
      repeat (2) @(posedge clk);
      #1;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_result", rsp_result, 0);
      check("rst_busy", busy, 0);
      rst_n = 1'b1;
      tick();
      check("idle_rsp_valid", rsp_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_req0_ready", req0_ready, 1);
      check("idle_req1_ready", req1_ready, 0);
      check("idle_sticky", {sticky_carry, sticky_ovf}, 0);

      // single ops with known flags
      do_op(0, ADD, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0);
      do_op(1, SUB, 4'h0, 4'h1, 4'hF, 1'b1, 1'b0, 1'b0);
      do_op(1, INC, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0, 1'b1);

      // both valid continuously: alternate grants, one response per 3 cycles
      rsp_ready = 1'b1;
      set_req(0, 1'b1, ADD, 4'h3, 4'h4);
      set_req(1, 1'b1, SUB, 4'h9, 4'h3);
      seen = 0;
      last_t = 0;
      for (int cyc = 0; cyc < 40 && seen < 4; cyc++) begin
         tick();
         if (rsp_valid) begin
            check("rr_id", rsp_id, seen % 2);
            check("rr_result", rsp_result, (seen % 2 == 0) ? 7 : 6);
            if (seen > 0)
               check("rr_spacing", cyc - last_t, 3);
            last_t = cyc;
            seen++;
            if (seen == 4) begin
               set_req(0, 1'b0, ADD, 4'h0, 4'h0);
               set_req(1, 1'b0, ADD, 4'h0, 4'h0);
            end
         end
      end
      check("rr_count", seen, 4);
      tick();
      check("rr_idle", busy, 0);

      // consumer stalls in RESP
      rsp_ready = 1'b0;
      set_req(0, 1'b1, ADD, 4'h3, 4'h5);
      #1;
      check("stall_accept", req0_ready, 1);
      tick();
      set_req(0, 1'b1, SUB, 4'h5, 4'h5);
      set_req(1, 1'b1, INC, 4'h2, 4'h0);
      tick();
      for (int i = 0; i < 5; i++) begin
         check("stall_rsp_valid", rsp_valid, 1);
         check("stall_result", {rsp_result, rsp_carry, rsp_overflow, rsp_zero}, {4'h8, 3'b010});
         check("stall_readies", {req0_ready, req1_ready}, 0);
         check("stall_busy", busy, 1);
         tick();
      end
      rsp_ready = 1'b1;
      #1;
      check("stall_release_valid", rsp_valid, 1);
      tick();
      check("stall_done_valid", rsp_valid, 0);
      check("stall_next_grant", {req0_ready, req1_ready}, 2'b01);
      set_req(0, 1'b0, ADD, 4'h0, 4'h0);
      set_req(1, 1'b0, ADD, 4'h0, 4'h0);
      tick();
      check("stall_single_hs", busy, 0);

      // reset while an op is in EXEC
      set_req(0, 1'b1, INC, 4'h3, 4'h0);
      #1;
      check("rstx_accept", req0_ready, 1);
      tick();
      set_req(0, 1'b0, INC, 4'h3, 4'h0);
      #1;
      check("rstx_in_exec", busy, 1);
      rst_n = 1'b0;
      #1;
      check("rstx_outputs", {rsp_valid, busy, rsp_result, rsp_carry, rsp_overflow, rsp_zero}, 0);
      #1;
      rst_n = 1'b1;
      tick();
      tick();
      check("rstx_discarded", {rsp_valid, busy}, 0);
      do_op(1, DEC, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0);

`ifdef ARITH_SCHED_STICKY_EN
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      check("sticky_cleared_start", {sticky_carry, sticky_ovf}, 0);
      do_op(0, DEC, 4'h8, 4'h0, 4'h7, 1'b0, 1'b1, 1'b0);
      check("sticky_ovf_set", sticky_ovf, 1);
      check("sticky_carry_clear", sticky_carry, 0);
      do_op(0, ADD, 4'h1, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0);
      check("sticky_ovf_hold", sticky_ovf, 1);
      sticky_clr = 1'b1;
      tick();
      sticky_clr = 1'b0;
      check("sticky_ovf_clr", sticky_ovf, 0);
`else
      do_op(0, DEC, 4'h8, 4'h0, 4'h7, 1'b0, 1'b1, 1'b0);
      check("sticky_tied", {sticky_carry, sticky_ovf}, 0);
`endif

      // randomized traffic against the reference model
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
      tick();
      pend[0] = 0; pend[1] = 0;
      inflight = 0; age = 0; m_last = 1;
      e_res = 0; e_c = 0; e_o = 0; e_z = 0; e_id = 0; m_sc = 0; m_so = 0;
      n_res = 0; n_c = 0; n_o = 0; n_z = 0; n_id = 0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int r = 0; r < 2; r++) begin
            if (!pend[r] && $urandom_range(0, 2) != 0) begin
               pend[r] = 1;
               pop[r]  = 2'($urandom_range(0, 3));
               pa[r]   = 4'($urandom_range(0, 15));
               pb[r]   = 4'($urandom_range(0, 15));
            end
         end
         set_req(0, pend[0], pop[0], pa[0], pb[0]);
         set_req(1, pend[1], pop[1], pa[1], pb[1]);
         rsp_ready  = ($urandom_range(0, 3) != 0);
         sticky_clr = ($urandom_range(0, 15) == 0);
         #1;
         g = (pend[0] && !pend[1]) ? 1'b0 : (pend[1] && !pend[0]) ? 1'b1 : !m_last;
         check("rnd_busy", busy, inflight);
         check("rnd_rsp_valid", rsp_valid, inflight && age >= 1);
         check("rnd_req0_ready", req0_ready, !inflight && !g);
         check("rnd_req1_ready", req1_ready, !inflight && g);
         check("rnd_payload", {rsp_id, rsp_result, rsp_carry, rsp_overflow, rsp_zero},
               {e_id, 4'(e_res), e_c, e_o, e_z});
         check("rnd_sticky", {sticky_carry, sticky_ovf}, {m_sc, m_so});
         exec_edge = inflight && age == 0;
         if (!inflight) begin
            if (pend[g]) begin
               inflight = 1;
               age      = 0;
               m_last   = g;
               pend[g]  = 0;
               n_id     = g;
               ref_op(pop[g], int'(pa[g]), int'(pb[g]), n_res, n_c, n_o, n_z);
            end
         end else if (age == 0) begin
            age = 1;
            e_res = n_res; e_c = n_c; e_o = n_o; e_z = n_z; e_id = n_id;
         end else if (rsp_ready) begin
            inflight = 0;
         end
`ifdef ARITH_SCHED_STICKY_EN
         if (sticky_clr) begin
            m_sc = 0; m_so = 0;
         end else if (exec_edge) begin
            m_sc = m_sc | n_c;
            m_so = m_so | n_o;
         end
`endif
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
